// File: rtl/lt_sequencer_pkg.sv
// Shared constants and types for the latency-tester sequencer.
// Box positions, result error codes, FSM encoding and the result payload.
package lt_sequencer_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned LAT_W  = 16;

    localparam logic [MODE_W-1:0] LT_POS_NONE        = 2'd0;
    localparam logic [MODE_W-1:0] LT_POS_TOPLEFT     = 2'd1;
    localparam logic [MODE_W-1:0] LT_POS_CENTER      = 2'd2;
    localparam logic [MODE_W-1:0] LT_POS_BOTTOMRIGHT = 2'd3;

    localparam logic [ERR_W-1:0] LT_ERR_OK       = 2'd0;
    localparam logic [ERR_W-1:0] LT_ERR_TIMEOUT  = 2'd1;
    localparam logic [ERR_W-1:0] LT_ERR_DARK_LIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DARK    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLD    = 2'd3
    } lt_state_e;

    typedef struct packed {
        logic [LAT_W-1:0] lat;
        logic [ERR_W-1:0] err;
        logic             valid;
    } lt_result_t;

endpackage

// File: rtl/lt_sequencer_sync_edge.sv
// Photodiode 2-FF synchronizer and frame-start (VSYNC falling edge) detector.
// Flops reset high: sensor reads dark and vsync idles inactive-high.
module lt_sync_edge (
    input  logic clk27,
    input  logic reset,
    input  logic sensor_n,
    input  logic vsync_in,
    output logic lit_c,
    output logic vs_fall_c
);

    logic sens_meta;
    logic sens_sync;
    logic vs_q;

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sens_meta <= 1'b1;
            sens_sync <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            sens_meta <= sensor_n;
            sens_sync <= sens_meta;
            vs_q      <= vsync_in;
        end
    end

    assign lit_c     = ~sens_sync;
    assign vs_fall_c = vs_q & ~vsync_in;

endmodule

// File: rtl/lt_sequencer.sv
// Latency-tester sequencer: drives the pattern generator frame-aligned and
// measures white-box-to-photodiode latency in microseconds.
module lt_sequencer
    import lt_sequencer_pkg::*;
#(
    parameter int unsigned DARK_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES = 2,
    parameter int unsigned US_DIV      = 27
) (
    input  logic              clk27,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              vsync_in,
    input  logic              sensor_n,
    output logic              lt_active,
    output logic [MODE_W-1:0] lt_mode,
    output logic              busy,
    output logic [LAT_W-1:0]  result_lat,
    output logic              result_valid,
    output logic [ERR_W-1:0]  result_err
);

    localparam int unsigned FRAME_MAX = (DARK_FRAMES > HOLD_FRAMES) ? DARK_FRAMES : HOLD_FRAMES;
    localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int unsigned PRESC_W   = $clog2(US_DIV + 1);

    logic lit_c;
    logic vs_fall_c;
    logic wrap_c;

    lt_state_e           state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [MODE_W-1:0]   lt_mode_d;
    lt_result_t          res_q, res_d;

    lt_sync_edge u_sync_edge (
        .clk27     (clk27),
        .reset     (reset),
        .sensor_n  (sensor_n),
        .vsync_in  (vsync_in),
        .lit_c     (lit_c),
        .vs_fall_c (vs_fall_c)
    );

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            presc_q   <= '0;
            lat_cnt_q <= '0;
            mode_q    <= LT_POS_NONE;
            res_q     <= '0;
            lt_active <= 1'b0;
            busy      <= 1'b0;
            lt_mode   <= LT_POS_NONE;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            presc_q   <= presc_d;
            lat_cnt_q <= lat_cnt_d;
            mode_q    <= mode_d;
            res_q     <= res_d;
            lt_active <= (state_d != ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            lt_mode   <= lt_mode_d;
        end
    end

    // Next-state, counters and result capture
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        presc_d   = presc_q;
        lat_cnt_d = lat_cnt_q;
        mode_d    = mode_q;
        res_d     = res_q;
        wrap_c    = (presc_q == PRESC_W'(US_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (start && (mode_sel != LT_POS_NONE)) begin
                    mode_d      = mode_sel;
                    res_d.valid = 1'b0;
                    res_d.err   = LT_ERR_OK;
                    frame_d     = FRAME_W'(DARK_FRAMES);
                    state_d     = ST_DARK;
                end
            end
            ST_DARK: begin
                if (vs_fall_c) begin
                    if (frame_q <= FRAME_W'(1)) begin
                        if (lit_c) begin
                            res_d.err = LT_ERR_DARK_LIT;
                            res_d.lat = '0;
                            frame_d   = FRAME_W'(HOLD_FRAMES);
                            state_d   = ST_HOLD;
                        end else begin
                            presc_d   = '0;
                            lat_cnt_d = '0;
                            state_d   = ST_MEASURE;
                        end
                    end else begin
                        frame_d = frame_q - FRAME_W'(1);
                    end
                end
            end
            ST_MEASURE: begin
                // Detection takes priority over the tick and the timeout
                if (lit_c) begin
                    res_d.lat = lat_cnt_q;
                    res_d.err = LT_ERR_OK;
                    frame_d   = FRAME_W'(HOLD_FRAMES);
                    state_d   = ST_HOLD;
                end else if (wrap_c) begin
                    presc_d = '0;
                    if (lat_cnt_q == '1) begin
                        res_d.lat = '1;
                        res_d.err = LT_ERR_TIMEOUT;
                        frame_d   = FRAME_W'(HOLD_FRAMES);
                        state_d   = ST_HOLD;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_HOLD: begin
                if (vs_fall_c) begin
                    if (frame_q <= FRAME_W'(1)) begin
                        frame_d     = '0;
                        res_d.valid = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_d = frame_q - FRAME_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Box shown only from MEASURE onward; HOLD keeps whatever was showing
        case (state_d)
            ST_MEASURE: lt_mode_d = mode_q;
            ST_HOLD:    lt_mode_d = lt_mode;
            default:    lt_mode_d = LT_POS_NONE;
        endcase
    end

    assign result_lat   = res_q.lat;
    assign result_err   = res_q.err;
    assign result_valid = res_q.valid;

endmodule

// File: tb/tb_lt_sequencer.sv
// Scoreboarded bench: instance A (US_DIV=3) covers detection, dark-lit, ignored
// starts, wrap coincidence and mid-run reset; instance B (US_DIV=1) covers the timeout.
module tb_lt_sequencer;
    import lt_sequencer_pkg::*;

    typedef struct packed {
        logic [15:0] lat;
        logic [1:0]  err;
    } exp_t;

    logic clk27 = 1'b0;
    always #5 clk27 = ~clk27;

    logic        reset_a = 1'b1, start_a = 1'b0, vsync_a = 1'b1, sensor_a = 1'b1;
    logic [1:0]  mode_a = 2'd0;
    logic        a_active, a_busy, a_valid;
    logic [1:0]  a_mode, a_err;
    logic [15:0] a_lat;

    logic        reset_b = 1'b1, start_b = 1'b0, vsync_b = 1'b1, sensor_b = 1'b1;
    logic [1:0]  mode_b = 2'd0;
    logic        b_active, b_busy, b_valid;
    logic [1:0]  b_mode, b_err;
    logic [15:0] b_lat;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    lt_sequencer #(.DARK_FRAMES(2), .HOLD_FRAMES(2), .US_DIV(3)) dut_a (
        .clk27(clk27), .reset(reset_a), .start(start_a), .mode_sel(mode_a),
        .vsync_in(vsync_a), .sensor_n(sensor_a), .lt_active(a_active), .lt_mode(a_mode),
        .busy(a_busy), .result_lat(a_lat), .result_valid(a_valid), .result_err(a_err)
    );

    lt_sequencer #(.DARK_FRAMES(2), .HOLD_FRAMES(2), .US_DIV(1)) dut_b (
        .clk27(clk27), .reset(reset_b), .start(start_b), .mode_sel(mode_b),
        .vsync_in(vsync_b), .sensor_n(sensor_b), .lt_active(b_active), .lt_mode(b_mode),
        .busy(b_busy), .result_lat(b_lat), .result_valid(b_valid), .result_err(b_err)
    );

    function automatic exp_t mk(input logic [15:0] l, input logic [1:0] e);
        exp_t r;
        r.lat = l;
        r.err = e;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on each rising result_valid
    task automatic monitor_a();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk27);
            if (a_valid && !prev) begin
                chk("a_result_expected", int'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_result_lat", int'(a_lat), int'(e.lat));
                    chk("a_result_err", int'(a_err), int'(e.err));
                end
            end
            prev = a_valid;
        end
    endtask

    task automatic monitor_b();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk27);
            if (b_valid && !prev) begin
                chk("b_result_expected", int'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk("b_result_lat", int'(b_lat), int'(e.lat));
                    chk("b_result_err", int'(b_err), int'(e.err));
                end
            end
            prev = b_valid;
        end
    endtask

    // One-cycle VSYNC low; returns 1 time unit after the edge that acts on it
    task automatic vs_a();
        repeat (4) @(posedge clk27);
        #1 vsync_a = 1'b0;
        @(posedge clk27);
        #1 vsync_a = 1'b1;
    endtask

    task automatic vs_b();
        repeat (4) @(posedge clk27);
        #1 vsync_b = 1'b0;
        @(posedge clk27);
        #1 vsync_b = 1'b1;
    endtask

    task automatic start_pulse_a(input logic [1:0] m);
        @(posedge clk27);
        #1 start_a = 1'b1;
        mode_a = m;
        @(posedge clk27);
        #1 start_a = 1'b0;
    endtask

    task automatic seq_a();
        repeat (3) @(posedge clk27);
        #1 reset_a = 1'b0;
        chk("a_rst_active", int'(a_active), 0);
        chk("a_rst_mode", int'(a_mode), 0);
        chk("a_rst_busy", int'(a_busy), 0);
        chk("a_rst_lat", int'(a_lat), 0);
        chk("a_rst_valid", int'(a_valid), 0);
        chk("a_rst_err", int'(a_err), 0);

        // Run 1: light 1000 cycles after MEASURE entry -> (1000+2)/3 = 334
        q_a.push_back(mk(16'd334, 2'd0));
        start_pulse_a(2'd2);
        chk("a_busy_after_start", int'(a_busy), 1);
        chk("a_active_after_start", int'(a_active), 1);
        chk("a_mode_dark0", int'(a_mode), 0);
        vs_a();
        chk("a_mode_dark1", int'(a_mode), 0);
        vs_a();
        chk("a_mode_measure", int'(a_mode), 2);
        repeat (1000) @(posedge clk27);
        #1 sensor_a = 1'b0;
        repeat (10) @(posedge clk27);
        #1 sensor_a = 1'b1;
        chk("a_mode_hold0", int'(a_mode), 2);
        chk("a_busy_hold", int'(a_busy), 1);
        vs_a();
        chk("a_mode_hold1", int'(a_mode), 2);
        chk("a_valid_hold1", int'(a_valid), 0);
        vs_a();
        chk("a_valid_done1", int'(a_valid), 1);
        chk("a_busy_done1", int'(a_busy), 0);
        chk("a_mode_idle1", int'(a_mode), 0);
        chk("a_active_idle1", int'(a_active), 0);

        // Run 2: sensor lit throughout the dark phase
        sensor_a = 1'b0;
        q_a.push_back(mk(16'd0, 2'd2));
        start_pulse_a(2'd3);
        vs_a();
        vs_a();
        chk("a_darklit_mode", int'(a_mode), 0);
        chk("a_darklit_err", int'(a_err), 2);
        chk("a_darklit_busy", int'(a_busy), 1);
        sensor_a = 1'b1;
        vs_a();
        chk("a_darklit_mode_hold", int'(a_mode), 0);
        vs_a();
        chk("a_valid_done2", int'(a_valid), 1);

        // Ignored start (mode 0), then accepted start, then start while busy
        start_pulse_a(2'd0);
        chk("a_ign_busy", int'(a_busy), 0);
        chk("a_ign_valid", int'(a_valid), 1);
        chk("a_ign_err", int'(a_err), 2);
        start_pulse_a(2'd1);
        chk("a_acc_busy", int'(a_busy), 1);
        chk("a_acc_valid", int'(a_valid), 0);
        chk("a_acc_err", int'(a_err), 0);
        start_pulse_a(2'd3);
        chk("a_busy_restart", int'(a_busy), 1);
        vs_a();
        vs_a();
        chk("a_mode_latched", int'(a_mode), 1);

        // Run 3: lit lands on the tick that would make lat_cnt 100 -> 99
        q_a.push_back(mk(16'd99, 2'd0));
        repeat (297) @(posedge clk27);
        #1 sensor_a = 1'b0;
        repeat (10) @(posedge clk27);
        #1 sensor_a = 1'b1;
        vs_a();
        vs_a();
        chk("a_valid_done3", int'(a_valid), 1);

        // Run 4: asynchronous reset mid-MEASURE, then a clean run
        start_pulse_a(2'd2);
        vs_a();
        vs_a();
        repeat (50) @(posedge clk27);
        #2 reset_a = 1'b1;
        #1;
        chk("a_mrst_active", int'(a_active), 0);
        chk("a_mrst_mode", int'(a_mode), 0);
        chk("a_mrst_busy", int'(a_busy), 0);
        chk("a_mrst_lat", int'(a_lat), 0);
        chk("a_mrst_valid", int'(a_valid), 0);
        chk("a_mrst_err", int'(a_err), 0);
        @(negedge clk27);
        reset_a = 1'b0;
        q_a.push_back(mk(16'd10, 2'd0));
        start_pulse_a(2'd3);
        vs_a();
        vs_a();
        chk("a_mode_after_rst", int'(a_mode), 3);
        repeat (30) @(posedge clk27);
        #1 sensor_a = 1'b0;
        repeat (10) @(posedge clk27);
        #1 sensor_a = 1'b1;
        vs_a();
        vs_a();
        chk("a_valid_done4", int'(a_valid), 1);
        chk("a_busy_done4", int'(a_busy), 0);
    endtask

    // Instance B: one tick per cycle, sensor never lit -> saturates at 65535
    task automatic seq_b();
        repeat (3) @(posedge clk27);
        #1 reset_b = 1'b0;
        q_b.push_back(mk(16'hFFFF, 2'd1));
        @(posedge clk27);
        #1 start_b = 1'b1;
        mode_b = 2'd1;
        @(posedge clk27);
        #1 start_b = 1'b0;
        vs_b();
        vs_b();
        chk("b_mode_measure", int'(b_mode), 1);
        repeat (65000) @(posedge clk27);
        #1;
        chk("b_valid_measuring", int'(b_valid), 0);
        chk("b_busy_measuring", int'(b_busy), 1);
        repeat (600) @(posedge clk27);
        #1;
        chk("b_timeout_err", int'(b_err), 1);
        chk("b_timeout_lat", int'(b_lat), 65535);
        chk("b_mode_hold", int'(b_mode), 1);
        vs_b();
        vs_b();
        chk("b_valid_done", int'(b_valid), 1);
        chk("b_busy_done", int'(b_busy), 0);
    endtask

    initial begin
        fork
            monitor_a();
            monitor_b();
        join_none
        fork
            seq_a();
            seq_b();
        join
        repeat (4) @(posedge clk27);
        #1;
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lt_sequencer.md
# lt_sequencer

Latency-tester sequencer that sits directly upstream of the test-pattern generator. It drives that block's `lt_active`/`lt_mode` inputs and watches its `VSYNC_out` to align pattern changes to frame start. It also samples an external photodiode and measures, in microseconds, the time from the frame where the white box first appears to the sensor detecting light. Results go to the host CPU through a latched result register.

## Interface
Parameters:
- `DARK_FRAMES`, 2: frames of black (`LT_POS_NONE`) shown before the box appears.
- `HOLD_FRAMES`, 2: frames the box stays lit after detection or timeout.
- `US_DIV`, 27: clk27 cycles per microsecond tick.

Ports:
- `clk27` in 1: 27 MHz pixel clock, the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a measurement.
- `mode_sel` in 2: box position for the run (`LT_POS_TOPLEFT`/`CENTER`/`BOTTOMRIGHT`).
- `vsync_in` in 1: generator `VSYNC_out`, negative polarity, synchronous to clk27.
- `sensor_n` in 1: photodiode comparator, active-low (low = light), asynchronous.
- `lt_active` out 1: to generator, high while a run is in progress.
- `lt_mode` out 2: to generator, pattern selection.
- `busy` out 1: high from accepted `start` until return to IDLE.
- `result_lat` out 16: latency in µs, held until the next accepted `start`.
- `result_valid` out 1: set when a run finishes, cleared on the next accepted `start`.
- `result_err` out 2: 0 ok, 1 timeout, 2 sensor lit during dark phase.

## Operation
- The sensor path uses a 2-FF synchronizer. `lit` is asserted when the synchronized sensor is low.
- Frame-start detection: `vs_fall` pulses for one cycle when registered `vsync_in` is 1 and the current `vsync_in` is 0.
- FSM states: IDLE, DARK, MEASURE, HOLD.
- IDLE:
  - `lt_active`=0, `lt_mode`=`LT_POS_NONE`.
  - An accepted `start` latches `mode_sel`, clears `result_valid`/`result_err`, loads the frame counter with `DARK_FRAMES`, and moves to DARK.
  - `start` is ignored when `mode_sel`==`LT_POS_NONE` or `busy`=1.
- DARK:
  - `lt_active`=1, `lt_mode`=`LT_POS_NONE`.
  - The frame counter decrements on each `vs_fall`.
  - On the `vs_fall` where the counter is 1:
    - if `lit`=1, set `result_err`=2, `result_lat`=0, and go to HOLD;
    - otherwise clear the prescaler and `lat_cnt` and go to MEASURE.
- MEASURE:
  - `lt_mode`=latched mode.
  - The prescaler counts 0..`US_DIV`-1. `lat_cnt` increments when the prescaler wraps.
  - `lit`=1 sets `result_lat`=`lat_cnt` and `result_err`=0, then goes to HOLD.
  - If `lat_cnt` is 16'hFFFF at a prescaler wrap, the block does not wrap. It sets `result_lat`=16'hFFFF and `result_err`=1, then goes to HOLD.
- HOLD:
  - `lt_mode` keeps its MEASURE value. If entered from DARK it is `LT_POS_NONE`.
  - The frame counter is loaded with `HOLD_FRAMES` on entry and decremented on each `vs_fall`.
  - On reaching 0, set `result_valid`=1 and go to IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `lt_active`=0, `lt_mode`=`LT_POS_NONE`, `busy`=0.
  - `result_lat`=0, `result_valid`=0, `result_err`=0.
  - State=IDLE; synchronizer flops=1 (dark).
- All outputs are registered.
- `busy` and `lt_active` rise in the cycle after `start` is sampled.
- `lt_mode` changes in the cycle after `vs_fall`, the same cycle that the prescaler and `lat_cnt` restart at 0.
- Sensor-to-capture latency is 3 cycles (2 sync + 1 capture). This is not compensated; resolution is 1 µs.
- `lit` and a prescaler wrap in the same cycle: the capture uses the pre-increment `lat_cnt`.
- `lit` and the timeout condition in the same cycle: detection wins (`result_err`=0).
- `start` while busy has no effect.
- `reset` mid-run returns to reset values immediately.

## Structure
- Shared package / include holds:
  - `LT_POS_NONE`=2'd0, `LT_POS_TOPLEFT`=2'd1, `LT_POS_CENTER`=2'd2, `LT_POS_BOTTOMRIGHT`=2'd3;
  - the `LT_ERR_*` codes;
  - the FSM state encoding.
- Sub-module `lt_sync_edge`: 2-FF synchronizer for `sensor_n` plus the registered falling-edge detector for `vsync_in`.

## Test plan
- Reset, then `start` with `mode_sel`=2 and `sensor_n` going low 1 000 000 cycles after the MEASURE entry:
  - `result_lat`=37037 (±1), `result_err`=0;
  - `lt_mode`=2 throughout HOLD;
  - `result_valid`=1 after 2 more frames.
- `sensor_n` held low from the start: at the end of DARK, `result_err`=2, `result_lat`=0, `lt_mode` stays 0.
- `sensor_n` never low: `lat_cnt` saturates at 65535, `result_err`=1, and the run completes normally.
- `start` pulsed while busy, and `start` with `mode_sel`=0: no state change and results are untouched.
- `reset` asserted mid-MEASURE: all outputs return to reset values asynchronously, and the next `start` runs cleanly.
- Sensor edge coincident with a prescaler wrap at `lat_cnt`=99: captured value is 99.
